am_access_scheduler: RTL and testbench



---
 rtl/am_access_scheduler_if.sv | 86 ++++++++
 rtl/am_access_scheduler.sv | 171 +++++++++++++++++
 tb/tb_am_access_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/am_access_scheduler_if.sv
// am_access_scheduler_if: command, router and response bundle.
// master = requester/router side, slave = scheduler.
interface am_access_scheduler_if #(
  parameter int P = 64,
  parameter int W = 8
);
  localparam int D = P * W;

  logic         req_valid;
  logic         req_ready;
  logic         req_dst_wen;
  logic         req_src0_ren;
  logic         req_src1_ren;
  logic         req_src2_ren;
  logic [3:0]   req_dst_ptr;
  logic [3:0]   req_src0_ptr;
  logic [3:0]   req_src1_ptr;
  logic [3:0]   req_src2_ptr;
  logic [D-1:0] req_dst_wdata;
  logic [P-1:0] req_dst_cs;
  logic [P-1:0] req_src0_cs;
  logic [P-1:0] req_src1_cs;
  logic [P-1:0] req_src2_cs;

  logic         am_dst_wen;
  logic         am_src0_ren;
  logic         am_src1_ren;
  logic         am_src2_ren;
  logic [3:0]   am_dst_ptr;
  logic [3:0]   am_src0_ptr;
  logic [3:0]   am_src1_ptr;
  logic [3:0]   am_src2_ptr;
  logic [D-1:0] am_dst_wdata;
  logic [P-1:0] am_dst_cs;
  logic [P-1:0] am_src0_cs;
  logic [P-1:0] am_src1_cs;
  logic [P-1:0] am_src2_cs;
  logic [D-1:0] am_src0_rdata;
  logic [D-1:0] am_src1_rdata;
  logic [D-1:0] am_src2_rdata;

  logic         rsp_valid;
  logic [D-1:0] rsp_src0_rdata;
  logic [D-1:0] rsp_src1_rdata;
  logic [D-1:0] rsp_src2_rdata;

  modport master (
    output req_valid, req_dst_wen,
    output req_src0_ren, req_src1_ren, req_src2_ren,
    output req_dst_ptr, req_src0_ptr,
    output req_src1_ptr, req_src2_ptr,
    output req_dst_wdata, req_dst_cs,
    output req_src0_cs, req_src1_cs, req_src2_cs,
    input  req_ready,
    input  am_dst_wen, am_src0_ren,
    input  am_src1_ren, am_src2_ren,
    input  am_dst_ptr, am_src0_ptr,
    input  am_src1_ptr, am_src2_ptr,
    input  am_dst_wdata, am_dst_cs,
    input  am_src0_cs, am_src1_cs, am_src2_cs,
    output am_src0_rdata, am_src1_rdata,
    output am_src2_rdata,
    input  rsp_valid, rsp_src0_rdata,
    input  rsp_src1_rdata, rsp_src2_rdata
  );

  modport slave (
    input  req_valid, req_dst_wen,
    input  req_src0_ren, req_src1_ren, req_src2_ren,
    input  req_dst_ptr, req_src0_ptr,
    input  req_src1_ptr, req_src2_ptr,
    input  req_dst_wdata, req_dst_cs,
    input  req_src0_cs, req_src1_cs, req_src2_cs,
    output req_ready,
    output am_dst_wen, am_src0_ren,
    output am_src1_ren, am_src2_ren,
    output am_dst_ptr, am_src0_ptr,
    output am_src1_ptr, am_src2_ptr,
    output am_dst_wdata, am_dst_cs,
    output am_src0_cs, am_src1_cs, am_src2_cs,
    input  am_src0_rdata, am_src1_rdata,
    input  am_src2_rdata,
    output rsp_valid, rsp_src0_rdata,
    output rsp_src1_rdata, rsp_src2_rdata
  );
endinterface

// File: rtl/am_access_scheduler.sv
// am_access_scheduler: splits one operand-access command into
// one or two bank-legal issue phases and returns the read operands.
module am_access_scheduler #(
  parameter int P     = 64,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  am_access_scheduler_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam int D = P * W;

  typedef enum logic [2:0] {
    IDLE, P1, P2, CAP, RESP
  } state_t;

  state_t state_q, state_d;

  // Access index: 0=dst, 1=src0, 2=src1, 3=src2
  logic [3:0]          en_q, en_d;
  logic [3:0][3:0]     ptr_q, ptr_d;
  logic [3:0][P-1:0]   cs_q, cs_d;
  logic [D-1:0]        wdata_q, wdata_d;
  logic [2:0][D-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0]        m1, m2, iss, capm;
  logic [1:0]        n0, n1;
  logic              split, accept;
  logic [2:0][D-1:0] rdata;

  assign rdata = {bus.am_src2_rdata,
                  bus.am_src1_rdata,
                  bus.am_src0_rdata};
  assign accept = bus.req_valid & bus.req_ready;

  // First two enabled accesses per bank issue in phase 1
  always_comb begin
    m1 = '0;
    m2 = '0;
    n0 = 2'd0;
    n1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (en_q[i]) begin
        if (ptr_q[i][3]) begin
          if (n1 < 2'd2) begin
            m1[i] = 1'b1;
            n1 = n1 + 2'd1;
          end else begin
            m2[i] = 1'b1;
          end
        end else begin
          if (n0 < 2'd2) begin
            m1[i] = 1'b1;
            n0 = n0 + 2'd1;
          end else begin
            m2[i] = 1'b1;
          end
        end
      end
    end
  end

  assign split = |m2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = P1;
      P1:      state_d = split ? P2 : CAP;
      P2:      state_d = CAP;
      CAP:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    iss           = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = rst;
        busy          = 1'b0;
      end
      P1:      iss = m1;
      P2:      iss = m2;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command capture, read-data capture and split counter
  always_comb begin
    en_d    = en_q;
    ptr_d   = ptr_q;
    cs_d    = cs_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    capm    = '0;
    if (state_q == P2)
      capm = m1;
    else if (state_q == CAP)
      capm = split ? m2 : m1;
    for (int k = 0; k < 3; k++)
      if (capm[k+1]) hold_d[k] = rdata[k];
    if (state_q == P1 && split && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
    if (accept) begin
      en_d    = {bus.req_src2_ren, bus.req_src1_ren,
                 bus.req_src0_ren, bus.req_dst_wen};
      ptr_d   = {bus.req_src2_ptr, bus.req_src1_ptr,
                 bus.req_src0_ptr, bus.req_dst_ptr};
      cs_d    = {bus.req_src2_cs, bus.req_src1_cs,
                 bus.req_src0_cs, bus.req_dst_cs};
      wdata_d = bus.req_dst_wdata;
      hold_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q    <= '0;
      ptr_q   <= '0;
      cs_q    <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      en_q    <= en_d;
      ptr_q   <= ptr_d;
      cs_q    <= cs_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.am_dst_wen     = iss[0];
  assign bus.am_src0_ren    = iss[1];
  assign bus.am_src1_ren    = iss[2];
  assign bus.am_src2_ren    = iss[3];
  assign bus.am_dst_ptr     = ptr_q[0];
  assign bus.am_src0_ptr    = ptr_q[1];
  assign bus.am_src1_ptr    = ptr_q[2];
  assign bus.am_src2_ptr    = ptr_q[3];
  assign bus.am_dst_cs      = cs_q[0];
  assign bus.am_src0_cs     = cs_q[1];
  assign bus.am_src1_cs     = cs_q[2];
  assign bus.am_src2_cs     = cs_q[3];
  assign bus.am_dst_wdata   = wdata_q;
  assign bus.rsp_src0_rdata = hold_q[0];
  assign bus.rsp_src1_rdata = hold_q[1];
  assign bus.rsp_src2_rdata = hold_q[2];
  assign conflict_cnt       = cnt_q;
endmodule

// File: tb/tb_am_access_scheduler.sv
// tb_am_access_scheduler: scoreboard bench with a 1-cycle
// router model; expected phases and responses queued at issue.
module tb_am_access_scheduler;
  localparam int P     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 3;
  localparam int D     = P * W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  am_access_scheduler_if #(.P(P), .W(W)) bus ();

  am_access_scheduler #(
    .P(P), .W(W), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    logic [3:0]   en;
    logic [15:0]  ptrs;
    logic [15:0]  cs;
    logic [D-1:0] wd;
  } phase_t;

  phase_t         ph_q[$];
  logic [3*D-1:0] rsp_q[$];
  logic [D-1:0]   mem[16];
  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Router: data only valid the cycle after its enable
  always @(posedge clk) begin
    bus.am_src0_rdata <= bus.am_src0_ren ?
      mem[bus.am_src0_ptr] : $urandom;
    bus.am_src1_rdata <= bus.am_src1_ren ?
      mem[bus.am_src1_ptr] : $urandom;
    bus.am_src2_rdata <= bus.am_src2_ren ?
      mem[bus.am_src2_ptr] : $urandom;
  end

  // Monitor: issued phases and responses against the scoreboard
  always @(negedge clk) begin
    logic [3:0] en_obs;
    phase_t ph;
    logic [3*D-1:0] r;
    en_obs = {bus.am_src2_ren, bus.am_src1_ren,
              bus.am_src0_ren, bus.am_dst_wen};
    if (en_obs != 4'd0) begin
      chk("phase_pending", 64'(ph_q.size() > 0), 1);
      if (ph_q.size() > 0) begin
        ph = ph_q.pop_front();
        chk("phase_en", 64'(en_obs), 64'(ph.en));
        chk("phase_ptr",
            64'({bus.am_src2_ptr, bus.am_src1_ptr,
                 bus.am_src0_ptr, bus.am_dst_ptr}),
            64'(ph.ptrs));
        chk("phase_cs",
            64'({bus.am_src2_cs, bus.am_src1_cs,
                 bus.am_src0_cs, bus.am_dst_cs}),
            64'(ph.cs));
        if (bus.am_dst_wen)
          chk("phase_wdata", 64'(bus.am_dst_wdata),
              64'(ph.wd));
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      chk("rsp_pending", 64'(rsp_q.size() > 0), 1);
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        chk("rsp_src0", 64'(bus.rsp_src0_rdata),
            64'(r[D-1:0]));
        chk("rsp_src1", 64'(bus.rsp_src1_rdata),
            64'(r[2*D-1:D]));
        chk("rsp_src2", 64'(bus.rsp_src2_rdata),
            64'(r[3*D-1:2*D]));
      end
    end
  end

  // Reference split: an access goes late if two earlier
  // enabled accesses already hit its bank
  function automatic void plan(input  logic [3:0]  en,
                               input  logic [15:0] ptrs,
                               output logic [3:0]  m1,
                               output logic [3:0]  m2);
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < 4; i++) begin
      int older;
      older = 0;
      if (en[i]) begin
        for (int j = 0; j < i; j++)
          if (en[j] && ptrs[4*j+3] == ptrs[4*i+3])
            older++;
        if (older < 2) m1[i] = 1'b1;
        else           m2[i] = 1'b1;
      end
    end
  endfunction

  task automatic drive(input logic [3:0]   en,
                       input logic [15:0]  ptrs,
                       input logic [15:0]  cs,
                       input logic [D-1:0] wd);
    bus.req_dst_wen   = en[0];
    bus.req_src0_ren  = en[1];
    bus.req_src1_ren  = en[2];
    bus.req_src2_ren  = en[3];
    bus.req_dst_ptr   = ptrs[3:0];
    bus.req_src0_ptr  = ptrs[7:4];
    bus.req_src1_ptr  = ptrs[11:8];
    bus.req_src2_ptr  = ptrs[15:12];
    bus.req_dst_cs    = cs[3:0];
    bus.req_src0_cs   = cs[7:4];
    bus.req_src1_cs   = cs[11:8];
    bus.req_src2_cs   = cs[15:12];
    bus.req_dst_wdata = wd;
  endtask

  task automatic send(input logic [3:0]   en,
                      input logic [15:0]  ptrs,
                      input logic [15:0]  cs,
                      input logic [D-1:0] wd,
                      input bit           abort);
    logic [3:0] m1, m2;
    logic [3*D-1:0] r;
    bit ok;
    int lat;
    plan(en, ptrs, m1, m2);
    drive(en, ptrs, cs, wd);
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_in_time", 64'(ok), 1);
    if (!ok) begin
      bus.req_valid = 1'b0;
      return;
    end
    if (m1 != 4'd0) ph_q.push_back('{m1, ptrs, cs, wd});
    if (m2 != 4'd0) ph_q.push_back('{m2, ptrs, cs, wd});
    if (!abort) begin
      r = '0;
      if (en[1]) r[D-1:0]     = mem[ptrs[7:4]];
      if (en[2]) r[2*D-1:D]   = mem[ptrs[11:8]];
      if (en[3]) r[3*D-1:2*D] = mem[ptrs[15:12]];
      rsp_q.push_back(r);
      if (m2 != 4'd0 && exp_cnt < CMAX) exp_cnt++;
    end
    @(posedge clk);
    if (abort) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_cnt = 0;
      chk("abort_en", 64'({bus.am_src2_ren, bus.am_src1_ren,
                           bus.am_src0_ren, bus.am_dst_wen}), 0);
      chk("abort_busy", 64'(busy), 0);
      chk("abort_ready_in_rst", 64'(bus.req_ready), 0);
      chk("abort_cnt", 64'(conflict_cnt), 0);
      chk("abort_rsp", 64'(bus.rsp_valid), 0);
      rst = 1'b1;
      #1;
      chk("abort_ready", 64'(bus.req_ready), 1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("abort_no_rsp", 64'(bus.rsp_valid), 0);
      end
      return;
    end
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom);
      end
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("rsp_latency", 64'(lat), (m2 != 4'd0) ? 4 : 3);
    chk("ready_in_resp", 64'(bus.req_ready), 0);
    chk("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
    @(negedge clk);
    chk("ready_after_resp", 64'(bus.req_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [3:0] t;
      t = 4'(i);
      mem[i] = {4{t, ~t}};
    end
    mem[1] = 32'hAAAA_AAAA;
    mem[9] = 32'hBBBB_BBBB;
    bus.req_valid = 1'b0;
    drive('0, '0, '0, '0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rsp", 64'(bus.rsp_valid), 0);
    chk("rst_cnt", 64'(conflict_cnt), 0);
    chk("rst_en", 64'({bus.am_src2_ren, bus.am_src1_ren,
                       bus.am_src0_ren, bus.am_dst_wen}), 0);
    rst = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(bus.req_ready), 1);
    @(negedge clk);

    send(4'b0110, 16'h0910, 16'h1234, 32'h0, 1'b0);
    send(4'b1110, 16'h2100, 16'h5678, 32'h0, 1'b0);
    send(4'b1111, 16'h9810, 16'h9ABC,
         32'hDEAD_BEEF, 1'b0);
    send(4'b1111, 16'hFCA8, 16'hF0F0,
         32'h1357_9BDF, 1'b0);
    send(4'b0000, 16'h3210, 16'h0000, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      send($urandom, $urandom, $urandom,
           $urandom, 1'b0);

    send(4'b1110, 16'h5430, 16'h1111, 32'h0, 1'b1);

    for (int i = 0; i < (1 << CNT_W) + 3; i++)
      send(4'b1110, 16'h3210 + 16'(i % 2), 16'(i),
           32'h0, 1'b0);
    chk("cnt_saturated", 64'(conflict_cnt), CMAX);

    repeat (3) @(negedge clk);
    chk("phase_q_drained", 64'(ph_q.size()), 0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
